alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_arb_pkg.sv | 25 ++
 rtl/rv32_alu.sv | 32 +++
 rtl/alu_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: FSM state type, the opcode
// constants, and width constants.
package alu_arb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32-style ALU. Shifts use op_2[4:0]; unknown opcodes give 0.
module rv32_alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] op_1_in,
  input  logic [31:0] op_2_in,
  input  logic [3:0]  opcode_in,
  output logic [31:0] result_out
);

  logic [4:0] shamt;
  assign shamt = op_2_in[4:0];

  // Select the operation result from the opcode.
  always_comb begin
    result_out = '0;
    case (opcode_in)
      OP_ADD:  result_out = op_1_in + op_2_in;
      OP_SUB:  result_out = op_1_in - op_2_in;
      OP_SLL:  result_out = op_1_in << shamt;
      OP_SLT:  result_out = {{(XLEN-1){1'b0}}, ($signed(op_1_in) < $signed(op_2_in))};
      OP_SLTU: result_out = {{(XLEN-1){1'b0}}, (op_1_in < op_2_in)};
      OP_XOR:  result_out = op_1_in ^ op_2_in;
      OP_SRL:  result_out = op_1_in >> shamt;
      OP_SRA:  result_out = $unsigned($signed(op_1_in) >>> shamt);
      OP_OR:   result_out = op_1_in | op_2_in;
      OP_AND:  result_out = op_1_in & op_2_in;
      default: result_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one rv32_alu, one operation in flight at a time,
// round-robin on contention. Optional grant counters: define ALU_ARB_STATS_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req0_valid_in,
  output logic        req0_ready_out,
  input  logic [31:0] req0_op_1_in,
  input  logic [31:0] req0_op_2_in,
  input  logic [3:0]  req0_opcode_in,
  input  logic        req1_valid_in,
  output logic        req1_ready_out,
  input  logic [31:0] req1_op_1_in,
  input  logic [31:0] req1_op_2_in,
  input  logic [3:0]  req1_opcode_in,
  output logic        rsp0_valid_out,
  input  logic        rsp0_ready_in,
  output logic [31:0] rsp0_result_out,
  output logic        rsp1_valid_out,
  input  logic        rsp1_ready_in,
  output logic [31:0] rsp1_result_out,
  output logic        busy_out,
  output logic [15:0] grant0_cnt_out,
  output logic [15:0] grant1_cnt_out
);

  state_e            state_q, state_d;
  logic              owner_q, last_owner_q;
  logic [XLEN-1:0]   op1_q, op2_q, result_q, alu_result;
  logic [3:0]        opcode_q;
  logic              sel;
  logic              accept, rsp_hs;

  // Requester 1 wins if it is alone, or if both are valid and req0 owned last.
  always_comb begin
    sel = 1'b0;
    if (req0_valid_in && req1_valid_in) sel = ~last_owner_q;
    else if (req1_valid_in)             sel = 1'b1;
  end

  assign accept = req0_ready_out | req1_ready_out;
  assign rsp_hs = (rsp0_valid_out & rsp0_ready_in) | (rsp1_valid_out & rsp1_ready_in);

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshakes and result gating.
  always_comb begin
    req0_ready_out = 1'b0;
    req1_ready_out = 1'b0;
    rsp0_valid_out = 1'b0;
    rsp1_valid_out = 1'b0;
    if (state_q == IDLE) begin
      req0_ready_out = req0_valid_in & ~sel;
      req1_ready_out = req1_valid_in &  sel;
    end
    if (state_q == RESP) begin
      rsp0_valid_out = ~owner_q;
      rsp1_valid_out =  owner_q;
    end
    busy_out        = (state_q != IDLE);
    rsp0_result_out = rsp0_valid_out ? result_q : '0;
    rsp1_result_out = rsp1_valid_out ? result_q : '0;
  end

  // Capture the accepted operation, the EXEC result and the round-robin owner.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      result_q     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      opcode_q     <= '0;
    end else begin
      if (accept) begin
        owner_q  <= sel;
        op1_q    <= sel ? req1_op_1_in   : req0_op_1_in;
        op2_q    <= sel ? req1_op_2_in   : req0_op_2_in;
        opcode_q <= sel ? req1_opcode_in : req0_opcode_in;
      end
      if (state_q == EXEC) result_q     <= alu_result;
      if (rsp_hs)          last_owner_q <= owner_q;
    end
  end

  rv32_alu u_alu (
    .op_1_in    (op1_q),
    .op_2_in    (op2_q),
    .opcode_in  (opcode_q),
    .result_out (alu_result)
  );

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant0_cnt_q, grant0_cnt_d;
  logic [CNT_W-1:0] grant1_cnt_q, grant1_cnt_d;

  // Saturating grant counters.
  always_comb begin
    grant0_cnt_d = grant0_cnt_q;
    grant1_cnt_d = grant1_cnt_q;
    if (req0_ready_out && grant0_cnt_q != '1) grant0_cnt_d = grant0_cnt_q + 1'b1;
    if (req1_ready_out && grant1_cnt_q != '1) grant1_cnt_d = grant1_cnt_q + 1'b1;
  end

  // Grant counter registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
    end else begin
      grant0_cnt_q <= grant0_cnt_d;
      grant1_cnt_q <= grant1_cnt_d;
    end
  end

  assign grant0_cnt_out = grant0_cnt_q;
  assign grant1_cnt_out = grant1_cnt_q;
`else
  assign grant0_cnt_out = '0;
  assign grant1_cnt_out = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_opc, req1_opc;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        busy;
  logic [15:0] cnt0, cnt1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .req0_valid_in   (req0_valid),
    .req0_ready_out  (req0_ready),
    .req0_op_1_in    (req0_op1),
    .req0_op_2_in    (req0_op2),
    .req0_opcode_in  (req0_opc),
    .req1_valid_in   (req1_valid),
    .req1_ready_out  (req1_ready),
    .req1_op_1_in    (req1_op1),
    .req1_op_2_in    (req1_op2),
    .req1_opcode_in  (req1_opc),
    .rsp0_valid_out  (rsp0_valid),
    .rsp0_ready_in   (rsp0_ready),
    .rsp0_result_out (rsp0_result),
    .rsp1_valid_out  (rsp1_valid),
    .rsp1_ready_in   (rsp1_ready),
    .rsp1_result_out (rsp1_result),
    .busy_out        (busy),
    .grant0_cnt_out  (cnt0),
    .grant1_cnt_out  (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Requesters must hold valid and operands until accepted.
  logic        hold0 = 1'b0, hold1 = 1'b0;
  logic [67:0] snap0, snap1;
  always @(posedge clk) begin
    if (hold0 && rst_n)
      assert (req0_valid && snap0 == {req0_op1, req0_op2, req0_opc}) else $error("req0 not held");
    if (hold1 && rst_n)
      assert (req1_valid && snap1 == {req1_op1, req1_op2, req1_opc}) else $error("req1 not held");
    hold0 <= rst_n && req0_valid && !req0_ready;
    hold1 <= rst_n && req1_valid && !req1_ready;
    snap0 <= {req0_op1, req0_op2, req0_opc};
    snap1 <= {req1_op1, req1_op2, req1_opc};
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic who, input logic [3:0] opc,
                       input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      req1_valid = 1'b1; req1_opc = opc; req1_op1 = a; req1_op2 = b;
    end else begin
      req0_valid = 1'b1; req0_opc = opc; req0_op1 = a; req0_op2 = b;
    end
  endtask

  // One uncontended operation: accept in cycle N, EXEC in N+1, response in N+2.
  task automatic do_op(input logic who, input logic [3:0] opc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string tag);
    @(negedge clk);
    drive(who, opc, a, b);
    #1;
    chk({tag, "_rdy"},  who ? req1_ready : req0_ready, 1);
    chk({tag, "_ordy"}, who ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_rsp"},  who ? rsp1_valid : rsp0_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_rspv"}, who ? rsp1_valid : rsp0_valid, 1);
    chk({tag, "_res"},  who ? rsp1_result : rsp0_result, exp);
    chk({tag, "_orspv"}, who ? rsp0_valid : rsp1_valid, 0);
    chk({tag, "_ores"},  who ? rsp0_result : rsp1_result, 0);
    if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk({tag, "_idle"}, busy, 0);
  endtask

  typedef struct {
    logic        who;
    logic [3:0]  opc;
    logic [31:0] a, b, exp;
  } vec_t;

  vec_t vecs[11];
  logic [15:0] exp_c0a, exp_c0, exp_c1;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_opc = '0;
    req1_op1 = '0; req1_op2 = '0; req1_opc = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state.
    do_reset();
    #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_rspv0", rsp0_valid, 0);
    chk("rst_rspv1", rsp1_valid, 0);
    chk("rst_res0", rsp0_result, 0);
    chk("rst_res1", rsp1_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt0", {16'd0, cnt0}, 0);
    chk("rst_cnt1", {16'd0, cnt1}, 0);

    // Contention straight after reset: req0 first, then req1, then req0 again.
    @(negedge clk);
    drive(1'b0, 4'b1000, 32'd5, 32'd3);
    drive(1'b1, 4'b1101, 32'h8000_0000, 32'd1);
    #1;
    chk("rr_rdy0_first", req0_ready, 1);
    chk("rr_rdy1_first", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("rr_exec_rdy1", req1_ready, 0);
    @(negedge clk);
    #1;
    chk("rr_rspv0", rsp0_valid, 1);
    chk("rr_res0", rsp0_result, 32'h0000_0002);
    chk("rr_rspv1_lo", rsp1_valid, 0);
    chk("rr_resp_rdy1", req1_ready, 0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk("rr_rdy1_second", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rr_rspv1", rsp1_valid, 1);
    chk("rr_res1", rsp1_result, 32'hC000_0000);
    chk("rr_rspv0_lo", rsp0_valid, 0);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    drive(1'b0, 4'b0000, 32'd1, 32'd1);
    drive(1'b1, 4'b0000, 32'd2, 32'd2);
    #1;
    chk("rr_rdy0_third", req0_ready, 1);
    chk("rr_rdy1_third", req1_ready, 0);

    // Directed ALU vectors, alternating requesters.
    do_reset();
    vecs[0]  = '{1'b0, 4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
    vecs[1]  = '{1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[2]  = '{1'b0, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{1'b1, 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{1'b1, 4'b0001, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020};
    vecs[5]  = '{1'b0, 4'b1111, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000};
    vecs[6]  = '{1'b1, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[7]  = '{1'b0, 4'b0101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
    vecs[8]  = '{1'b1, 4'b0111, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608};
    vecs[9]  = '{1'b0, 4'b0110, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[10] = '{1'b1, 4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
`ifdef ALU_ARB_STATS_EN
    exp_c0a = 16'd3; exp_c0 = 16'd6; exp_c1 = 16'd5;
`else
    exp_c0a = 16'd0; exp_c0 = 16'd0; exp_c1 = 16'd0;
`endif
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].who, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      if (i == 2) begin
        chk("cnt0_after3", {16'd0, cnt0}, {16'd0, exp_c0a});
        chk("cnt1_after3", {16'd0, cnt1}, 0);
      end
    end
    chk("cnt0_end", {16'd0, cnt0}, {16'd0, exp_c0});
    chk("cnt1_end", {16'd0, cnt1}, {16'd0, exp_c1});

`ifdef ALU_ARB_STATS_EN
    // Saturation: preload the counter at its ceiling, then grant once more.
    @(negedge clk);
    force dut.grant0_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.grant0_cnt_q;
    do_op(1'b0, 4'b0000, 32'd1, 32'd2, 32'd3, "sat");
    chk("cnt0_sat", {16'd0, cnt0}, 32'h0000_FFFF);
`endif

    // Response back-pressure, then reset in the middle of the next operation.
    do_reset();
    @(negedge clk);
    drive(1'b0, 4'b0000, 32'd1, 32'd2);
    #1;
    chk("stall_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'b1000, 32'd10, 32'd4);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d_rspv", k), rsp0_valid, 1);
      chk($sformatf("stall%0d_res", k), rsp0_result, 32'd3);
      chk($sformatf("stall%0d_rdy", k), {req0_ready, req1_ready}, 0);
      chk($sformatf("stall%0d_busy", k), busy, 1);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1;
    chk("hs_cycle_rdy1", req1_ready, 0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk("after_hs_rdy1", req1_ready, 1);
    chk("after_hs_busy", busy, 0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("exec_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstx_outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 0);
    chk("rstx_res", rsp0_result | rsp1_result, 0);
    chk("rstx_cnt", {cnt0, cnt1}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstx_norsp%0d", k), {rsp0_valid, rsp1_valid, busy}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
